// File: rtl/sa_pkg.sv
// sa_pkg: shared types for the systolic-array partial-sum accumulation stage
package sa_pkg;

    localparam int SA_WIDTH = 8;
    localparam int SA_COL   = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        WRITE,
        DONE
    } psum_accum_state_e;

    typedef logic [SA_COL-1:0][SA_WIDTH-1:0] lane_vec_t;

endpackage

// File: rtl/sa_vec_add.sv
// sa_vec_add: COL-lane wrap-around adder with a zero-select on the psum operand
module sa_vec_add #(
    parameter int WIDTH = 8,
    parameter int COL   = 4
) (
    input  logic [COL*WIDTH-1:0] a,
    input  logic [COL*WIDTH-1:0] b,
    input  logic                 zero_b,
    output logic [COL*WIDTH-1:0] sum
);

    for (genvar i = 0; i < COL; i++) begin : g_lane
        assign sum[i*WIDTH +: WIDTH] = a[i*WIDTH +: WIDTH] + (zero_b ? '0 : b[i*WIDTH +: WIDTH]);
    end

endmodule

// File: rtl/sa_psum_accum.sv
// sa_psum_accum: accumulates array rows into the psum buffer, or emits to the output buffer on the last K-tile
module sa_psum_accum
    import sa_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int COL   = 4,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 start_i,
    input  logic [AW-1:0]        cfg_base_i,
    input  logic [AW:0]          cfg_rows_i,
    input  logic                 cfg_first_i,
    input  logic                 cfg_last_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [COL*WIDTH-1:0] in_data_i,
    output logic                 ps_mem_cenb_o,
    output logic                 ps_mem_wenb_o,
    output logic [AW-1:0]        ps_mem_addr_o,
    output logic [COL*WIDTH-1:0] ps_mem_data_o,
    input  logic [COL*WIDTH-1:0] ps_mem_data_i,
    output logic                 ob_mem_cenb_o,
    output logic                 ob_mem_wenb_o,
    output logic [AW-1:0]        ob_mem_addr_o,
    output logic [COL*WIDTH-1:0] ob_mem_data_o,
    output logic                 busy_o,
    output logic                 done_o
);

    psum_accum_state_e state_q, state_d;

    logic [AW:0]          rows_q, cnt_q;
    logic [AW-1:0]        addr_q;
    logic                 first_q, last_q;
    logic [COL*WIDTH-1:0] held_q, sum;
    logic                 last_row, ps_rd, ps_wr, ob_wr;

    assign last_row = (cnt_q + (AW+1)'(1)) == rows_q;

    sa_vec_add #(.WIDTH(WIDTH), .COL(COL)) u_add (
        .a      (held_q),
        .b      (ps_mem_data_i),
        .zero_b (first_q),
        .sum    (sum)
    );

    // state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = !start_i ? IDLE : (cfg_rows_i == '0 ? DONE : ACCEPT);
            ACCEPT:  state_d = in_valid_i ? WRITE : ACCEPT;
            WRITE:   state_d = last_row ? DONE : ACCEPT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // pass config, row counter, address and held row; cfg only latched from IDLE
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rows_q  <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            held_q  <= '0;
        end else begin
            if (state_q == IDLE && start_i) begin
                rows_q  <= cfg_rows_i;
                cnt_q   <= '0;
                addr_q  <= cfg_base_i;
                first_q <= cfg_first_i;
                last_q  <= cfg_last_i;
            end
            if (state_q == ACCEPT && in_valid_i) held_q <= in_data_i;
            if (state_q == WRITE) begin
                cnt_q  <= cnt_q + (AW+1)'(1);
                addr_q <= addr_q + AW'(1);
            end
        end
    end

    assign ps_rd = state_q == ACCEPT && in_valid_i && !first_q;
    assign ps_wr = state_q == WRITE && !last_q;
    assign ob_wr = state_q == WRITE && last_q;

    // handshake, status and memory port decode; idle ports park at cenb/wenb=1, addr/data=0
    always_comb begin
        in_ready_o    = state_q == ACCEPT;
        busy_o        = state_q != IDLE;
        done_o        = state_q == DONE;
        ps_mem_cenb_o = !(ps_rd || ps_wr);
        ps_mem_wenb_o = !ps_wr;
        ps_mem_addr_o = (ps_rd || ps_wr) ? addr_q : '0;
        ps_mem_data_o = ps_wr ? sum : '0;
        ob_mem_cenb_o = !ob_wr;
        ob_mem_wenb_o = !ob_wr;
        ob_mem_addr_o = ob_wr ? addr_q : '0;
        ob_mem_data_o = ob_wr ? sum : '0;
    end

endmodule

// File: tb/tb_sa_psum_accum.sv
// tb_sa_psum_accum: scoreboard bench for sa_psum_accum with psum/output buffer models
module tb_sa_psum_accum;
    import sa_pkg::*;

    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);

    typedef struct {
        bit        ob;
        int        addr;
        lane_vec_t data;
    } exp_t;

    logic            clk_i = 1'b0;
    logic            rstn_i = 1'b0;
    logic            start_i = 1'b0;
    logic [AW-1:0]   cfg_base_i = '0;
    logic [AW:0]     cfg_rows_i = '0;
    logic            cfg_first_i = 1'b0;
    logic            cfg_last_i = 1'b0;
    logic            in_valid_i = 1'b0;
    logic            in_ready_o;
    lane_vec_t       in_data_i = '0;
    logic            ps_mem_cenb_o, ps_mem_wenb_o, ob_mem_cenb_o, ob_mem_wenb_o;
    logic [AW-1:0]   ps_mem_addr_o, ob_mem_addr_o;
    lane_vec_t       ps_mem_data_o, ob_mem_data_o;
    lane_vec_t       ps_rdata = '0;
    logic            busy_o, done_o;

    lane_vec_t ps_mem [DEPTH] = '{default: '0};
    lane_vec_t ob_mem [DEPTH] = '{default: '0};
    lane_vec_t ref_ps [DEPTH] = '{default: '0};
    lane_vec_t row_data [8];
    exp_t      sb [$];

    int ps_rd_cnt = 0, ps_wr_cnt = 0, ob_wr_cnt = 0;
    int checks = 0, errors = 0;

    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    lane_vec_t     pre_data = '0;

    sa_psum_accum #(.WIDTH(SA_WIDTH), .COL(SA_COL), .DEPTH(DEPTH)) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .start_i       (start_i),
        .cfg_base_i    (cfg_base_i),
        .cfg_rows_i    (cfg_rows_i),
        .cfg_first_i   (cfg_first_i),
        .cfg_last_i    (cfg_last_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_data_i     (in_data_i),
        .ps_mem_cenb_o (ps_mem_cenb_o),
        .ps_mem_wenb_o (ps_mem_wenb_o),
        .ps_mem_addr_o (ps_mem_addr_o),
        .ps_mem_data_o (ps_mem_data_o),
        .ps_mem_data_i (ps_rdata),
        .ob_mem_cenb_o (ob_mem_cenb_o),
        .ob_mem_wenb_o (ob_mem_wenb_o),
        .ob_mem_addr_o (ob_mem_addr_o),
        .ob_mem_data_o (ob_mem_data_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic lane_vec_t add_lanes(input lane_vec_t a, input lane_vec_t b);
        lane_vec_t r;
        for (int l = 0; l < SA_COL; l++) r[l] = a[l] + b[l];
        return r;
    endfunction

    // synchronous buffer models: 1-cycle psum read latency
    always @(posedge clk_i) begin
        if (pre_en) ps_mem[pre_addr] <= pre_data;
        if (!ps_mem_cenb_o && ps_mem_wenb_o) begin
            ps_rdata  <= ps_mem[ps_mem_addr_o];
            ps_rd_cnt <= ps_rd_cnt + 1;
        end
        if (!ps_mem_cenb_o && !ps_mem_wenb_o) begin
            ps_mem[ps_mem_addr_o] <= ps_mem_data_o;
            ps_wr_cnt             <= ps_wr_cnt + 1;
        end
        if (!ob_mem_cenb_o && !ob_mem_wenb_o) begin
            ob_mem[ob_mem_addr_o] <= ob_mem_data_o;
            ob_wr_cnt             <= ob_wr_cnt + 1;
        end
    end

    // scoreboard: every write is matched against the oldest expected write
    always @(negedge clk_i) begin
        exp_t e;
        bit   ps_w, ob_w;
        ps_w = !ps_mem_cenb_o && !ps_mem_wenb_o;
        ob_w = !ob_mem_cenb_o && !ob_mem_wenb_o;
        if (ps_w || ob_w) begin
            if (sb.size() == 0) check("sb_extra_write", 1, 0);
            else begin
                e = sb.pop_front();
                check("wr_to_ob", ob_w, e.ob);
                check("wr_addr", ob_w ? ob_mem_addr_o : ps_mem_addr_o, e.addr);
                check("wr_data", ob_w ? ob_mem_data_o : ps_mem_data_o, e.data);
            end
        end
    end

    task automatic run_pass(input int base, input int rows, input bit first, input bit last,
                            input int gap_at, input bit poke);
        int   n, k, rd0, psw0, obw0;
        exp_t e;
        rd0 = ps_rd_cnt; psw0 = ps_wr_cnt; obw0 = ob_wr_cnt;
        @(negedge clk_i);
        cfg_base_i = AW'(base); cfg_rows_i = (AW+1)'(rows);
        cfg_first_i = first; cfg_last_i = last; start_i = 1'b1;
        @(posedge clk_i);
        n = 0;
        @(negedge clk_i);
        start_i = 1'b0;
        check("busy_after_start", busy_o, 1);
        for (int r = 0; r < rows; r++) begin
            k = 0;
            while (!in_ready_o && k < 20) begin
                @(posedge clk_i); n++;
                @(negedge clk_i); k++;
            end
            check("ready_timeout", k < 20, 1);
            if (r == gap_at) begin
                repeat (3) begin
                    check("gap_ready", in_ready_o, 1);
                    @(posedge clk_i); n++;
                    @(negedge clk_i);
                end
            end
            in_valid_i = 1'b1;
            in_data_i  = row_data[r];
            e.ob   = last;
            e.addr = (base + r) % DEPTH;
            e.data = first ? row_data[r] : add_lanes(row_data[r], ref_ps[e.addr]);
            if (!last) ref_ps[e.addr] = e.data;
            sb.push_back(e);
            @(posedge clk_i); n++;
            @(negedge clk_i);
            in_valid_i = 1'b0;
            in_data_i  = lane_vec_t'($urandom);
            if (poke && r == 0) begin
                start_i = 1'b1; cfg_base_i = AW'(base + 7); cfg_rows_i = 1;
                cfg_first_i = !first; cfg_last_i = !last;
                @(posedge clk_i); n++;
                @(negedge clk_i);
                start_i = 1'b0;
            end
        end
        k = 0;
        while (!done_o && k < 50) begin
            @(posedge clk_i); n++;
            @(negedge clk_i); k++;
        end
        check("done_latency", n, 2 * rows + ((gap_at >= 0 && gap_at < rows) ? 3 : 0));
        @(posedge clk_i);
        @(negedge clk_i);
        check("done_one_cycle", done_o, 0);
        check("busy_after_done", busy_o, 0);
        check("sb_drained", sb.size(), 0);
        check("ps_reads", ps_rd_cnt - rd0, first ? 0 : rows);
        check("ps_writes", ps_wr_cnt - psw0, last ? 0 : rows);
        check("ob_writes", ob_wr_cnt - obw0, last ? rows : 0);
    endtask

    initial begin
        int psw0;
        #1;
        check("rst_in_ready", in_ready_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_cenb_wenb", {ps_mem_cenb_o, ps_mem_wenb_o, ob_mem_cenb_o, ob_mem_wenb_o}, 4'hF);
        @(negedge clk_i);
        rstn_i = 1'b1;

        row_data[0] = {8'd1, 8'd2, 8'd3, 8'd4};
        row_data[1] = {8'd5, 8'd6, 8'd7, 8'd8};
        run_pass(0, 2, 1'b1, 1'b0, -1, 1'b0);
        check("t1_ps0", ps_mem[0], {8'd1, 8'd2, 8'd3, 8'd4});
        check("t1_ps1", ps_mem[1], {8'd5, 8'd6, 8'd7, 8'd8});

        run_pass(0, 2, 1'b0, 1'b1, -1, 1'b0);
        check("t2_ob0", ob_mem[0], {8'd2, 8'd4, 8'd6, 8'd8});
        check("t2_ob1", ob_mem[1], {8'd10, 8'd12, 8'd14, 8'd16});
        check("t2_ps0_kept", ps_mem[0], {8'd1, 8'd2, 8'd3, 8'd4});

        @(negedge clk_i);
        pre_en = 1'b1; pre_addr = AW'(20); pre_data = {4{8'hF0}};
        ref_ps[20] = {4{8'hF0}};
        @(negedge clk_i);
        pre_en = 1'b0;
        row_data[0] = {4{8'h20}};
        run_pass(20, 1, 1'b0, 1'b0, -1, 1'b0);
        check("ovf_wrap", ps_mem[20], {4{8'h10}});

        row_data[0] = {8'hA1, 8'hA2, 8'hA3, 8'hA4};
        row_data[1] = {8'hB1, 8'hB2, 8'hB3, 8'hB4};
        run_pass(DEPTH - 1, 2, 1'b1, 1'b0, -1, 1'b0);
        check("wrap_top", ps_mem[DEPTH-1], {8'hA1, 8'hA2, 8'hA3, 8'hA4});
        check("wrap_zero", ps_mem[0], {8'hB1, 8'hB2, 8'hB3, 8'hB4});

        run_pass(5, 0, 1'b0, 1'b0, -1, 1'b0);

        for (int i = 0; i < 3; i++) row_data[i] = lane_vec_t'($urandom);
        run_pass(30, 3, 1'b0, 1'b1, 1, 1'b1);

        psw0 = ps_wr_cnt;
        @(negedge clk_i);
        cfg_base_i = AW'(10); cfg_rows_i = 3; cfg_first_i = 1'b0; cfg_last_i = 1'b0; start_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0; in_valid_i = 1'b1; in_data_i = {4{8'h55}};
        @(posedge clk_i);
        #2 rstn_i = 1'b0;
        #1;
        check("mid_rst_cenb_wenb", {ps_mem_cenb_o, ps_mem_wenb_o, ob_mem_cenb_o, ob_mem_wenb_o}, 4'hF);
        check("mid_rst_ready", in_ready_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_done", done_o, 0);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        check("mid_rst_no_write", ps_wr_cnt - psw0, 0);
        check("post_rst_busy", busy_o, 0);

        for (int i = 0; i < 4; i++) row_data[i] = lane_vec_t'($urandom);
        run_pass(40, 4, 1'b1, 1'b1, -1, 1'b0);
        check("post_rst_ob40", ob_mem[40], row_data[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
